// File: rtl/tft_fetch_ctrl_if.sv
// Memory read port of the TFT fetch controller.
// Request/grant handshake plus in-order read returns.
interface tft_fetch_ctrl_if;
    logic        mem_req;
    logic [16:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [15:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_gnt,
        input  mem_rvalid,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_gnt,
        output mem_rvalid,
        output mem_rdata
    );
endinterface

// File: rtl/tft_fetch_ctrl.sv
// TFT frame fetch controller: reads a frame from memory into a
// show-ahead pixel FIFO and streams it out on tft_de.
module tft_fetch_ctrl #(
    parameter int IMG_W      = 480,
    parameter int IMG_H      = 272,
    parameter int FIFO_DEPTH = 16,
    parameter int PREFILL    = 8,
    parameter int MAX_OUTS   = 4
) (
    input  logic             clk9M,
    input  logic             rst,
    input  logic             en,
    input  logic             frame_start,
    input  logic             tft_de,
    tft_fetch_ctrl_if.master mem,
    output logic [15:0]      pix_data,
    output logic             underrun,
    output logic             frame_err,
    output logic             busy,
    output logic [4:0]       fill_level
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int OW = $clog2(MAX_OUTS + 1) + 1;
    localparam logic [16:0]   NPIX  = 17'(IMG_W * IMG_H);
    localparam logic [16:0]   LAST  = 17'(IMG_W * IMG_H - 1);
    localparam logic [5:0]    DEPTH = 6'(FIFO_DEPTH);
    localparam logic [4:0]    PRE   = 5'(PREFILL);
    localparam logic [OW-1:0] MAXO  = OW'(MAX_OUTS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SYNC,
        S_PREFILL,
        S_STREAM
    } state_t;

    state_t          state, state_n;
    logic [15:0]     fifo [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [4:0]      count;
    logic [OW-1:0]   outs, drop;
    logic [16:0]     addr, pix_cnt;
    logic            iss_done;
    logic            flush, clr_sticky;
    logic            xfer, rv_drop, rv_live, push, adv, pop;

    assign busy       = (state == S_PREFILL) || (state == S_STREAM);
    assign fill_level = count;

    // Reads are throttled so FIFO space covers every outstanding return;
    // returns owed to an abandoned frame also count against MAX_OUTS.
    assign mem.mem_req  = busy && !iss_done
                       && (({1'b0, count} + 6'(outs)) < DEPTH)
                       && ((outs + drop) < MAXO);
    assign mem.mem_addr = addr;

    assign xfer    = mem.mem_req && mem.mem_gnt;
    assign rv_drop = mem.mem_rvalid && (drop != '0);
    assign rv_live = mem.mem_rvalid && (drop == '0) && (outs != '0);
    assign push    = rv_live && !flush;
    assign adv     = (state == S_STREAM) && tft_de
                  && (pix_cnt != NPIX) && !flush;
    assign pop     = adv && (count != '0);
    assign pix_data = pop ? fifo[rd_ptr] : 16'h0000;

    // State register
    always_ff @(posedge clk9M) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    // Next state and flush/clear decisions
    always_comb begin
        state_n    = state;
        flush      = 1'b0;
        clr_sticky = 1'b0;
        if (!en) begin
            state_n    = S_IDLE;
            flush      = 1'b1;
            clr_sticky = 1'b1;
        end else begin
            unique case (state)
                S_IDLE: state_n = S_SYNC;
                S_SYNC: begin
                    if (frame_start) begin
                        state_n = S_PREFILL;
                        flush   = 1'b1;
                    end
                end
                S_PREFILL: begin
                    if (frame_start) begin
                        state_n = S_PREFILL;
                        flush   = 1'b1;
                    end else if (count >= PRE) begin
                        state_n = S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (frame_start) begin
                        state_n = S_PREFILL;
                        flush   = 1'b1;
                    end else if (pix_cnt == NPIX && outs == '0) begin
                        state_n = S_SYNC;
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    // FIFO storage, written by accepted read returns
    always_ff @(posedge clk9M) begin
        if (push) fifo[wr_ptr] <= mem.mem_rdata;
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk9M) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + 5'(push) - 5'(pop);
        end
    end

    // Outstanding reads; on flush they become returns to discard
    always_ff @(posedge clk9M) begin
        if (rst) begin
            outs <= '0;
            drop <= '0;
        end else if (flush) begin
            outs <= '0;
            drop <= drop - OW'(rv_drop) + outs
                  + OW'(xfer) - OW'(rv_live);
        end else begin
            outs <= outs + OW'(xfer) - OW'(rv_live);
            drop <= drop - OW'(rv_drop);
        end
    end

    // Read address; holds the last pixel once it has been requested
    always_ff @(posedge clk9M) begin
        if (rst || flush) begin
            addr     <= '0;
            iss_done <= 1'b0;
        end else if (xfer) begin
            if (addr == LAST) iss_done <= 1'b1;
            else              addr     <= addr + 1'b1;
        end
    end

    // Displayed pixel count, underrun slots included
    always_ff @(posedge clk9M) begin
        if (rst || flush) pix_cnt <= '0;
        else if (adv)     pix_cnt <= pix_cnt + 1'b1;
    end

    // Sticky error flags
    always_ff @(posedge clk9M) begin
        if (rst || clr_sticky) begin
            underrun  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (adv && count == '0)  underrun  <= 1'b1;
            if (frame_start && busy) frame_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_tft_fetch_ctrl.sv
// Randomized scoreboard bench for tft_fetch_ctrl on a reduced frame.
// Memory image: pixel i holds pix_of(i); real pixels must arrive in order.
module tb_tft_fetch_ctrl;
    localparam int W    = 16;
    localparam int H    = 6;
    localparam int N    = W * H;
    localparam int PRE  = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        frame_start = 1'b0;
    logic        tft_de;
    logic [15:0] pix_data;
    logic        underrun, frame_err, busy;
    logic [4:0]  fill_level;

    tft_fetch_ctrl_if bus();

    tft_fetch_ctrl #(
        .IMG_W(W), .IMG_H(H), .FIFO_DEPTH(16),
        .PREFILL(PRE), .MAX_OUTS(4)
    ) dut (
        .clk9M(clk), .rst(rst), .en(en),
        .frame_start(frame_start), .tft_de(tft_de),
        .mem(bus), .pix_data(pix_data),
        .underrun(underrun), .frame_err(frame_err),
        .busy(busy), .fill_level(fill_level)
    );

    int checks = 0;
    int failures = 0;
    logic [15:0] exp_q[$];

    int gnt_pct = 100;
    int lat_lo = 2;
    int lat_hi = 2;
    int de_mode = 0;
    int de_pct = 0;
    int gnt_block = 0;
    int xfer_cnt = 0;
    int last_addr = -1;
    int real_cnt = 0;
    bit track = 1'b0;
    int fill_cyc = -1;
    int pix_cyc = -1;

    int rc = 0;
    int last_due = 0;
    int pa[$];
    int pd[$];
    int mc = 0;
    bit hold_prev = 1'b0;
    bit abort_prev = 1'b1;
    logic [16:0] addr_prev = '0;

    initial forever #5 clk = ~clk;

    function automatic logic [15:0] pix_of(input int a);
        logic [14:0] v;
        v = 15'(a * 7919 + 311);
        return {1'b1, v};
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame();
        step();
        exp_q.delete();
        for (int i = 0; i < N; i++) exp_q.push_back(pix_of(i));
        xfer_cnt = 0;
        real_cnt = 0;
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n;
        n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(name, busy, 1'b0);
    endtask

    task automatic wait_pops(input int k, input int budget);
        int n;
        n = 0;
        while (real_cnt < k && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("pops_reached", real_cnt >= k, 1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_mem_req"}, bus.mem_req, 0);
        chk({tag, "_mem_addr"}, bus.mem_addr, 0);
        chk({tag, "_pix_data"}, pix_data, 0);
        chk({tag, "_underrun"}, underrun, 0);
        chk({tag, "_frame_err"}, frame_err, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_fill_level"}, fill_level, 0);
    endtask

    task automatic clean_frame(input string tag);
        gnt_pct = 70; lat_lo = 1; lat_hi = 4;
        de_mode = 1; de_pct = 40;
        start_frame();
        wait_pops(30, 1000);
        step();
        gnt_block = 5;
        wait_idle(4000, {tag, "_done"});
        chk({tag, "_all_pixels"}, exp_q.size(), 0);
        chk({tag, "_xfers"}, xfer_cnt, N);
        chk({tag, "_last_addr"}, last_addr, N - 1);
        chk({tag, "_underrun"}, underrun, 0);
        chk({tag, "_frame_err"}, frame_err, 0);
    endtask

    // Memory model and display-enable driver
    initial begin
        int d;
        bus.mem_gnt = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata = '0;
        tft_de = 1'b0;
        forever begin
            step();
            rc++;
            if (pd.size() > 0 && pd[0] <= rc) begin
                bus.mem_rvalid = 1'b1;
                bus.mem_rdata = pix_of(pa.pop_front());
                void'(pd.pop_front());
            end else begin
                bus.mem_rvalid = 1'b0;
                bus.mem_rdata = 16'($urandom);
            end
            if (gnt_block > 0) begin
                bus.mem_gnt = 1'b0;
                gnt_block--;
            end else begin
                bus.mem_gnt = ($urandom_range(99) < gnt_pct);
            end
            if (bus.mem_req && bus.mem_gnt) begin
                d = rc + int'($urandom_range(lat_hi, lat_lo));
                if (d <= last_due) d = last_due + 1;
                last_due = d;
                pa.push_back(int'(bus.mem_addr));
                pd.push_back(d);
                xfer_cnt++;
                last_addr = int'(bus.mem_addr);
            end
            case (de_mode)
                2: tft_de = 1'b1;
                1: tft_de = ($urandom_range(99) < de_pct);
                default: tft_de = 1'b0;
            endcase
        end
    end

    // Monitor: handshake stability and in-order pixel scoreboard
    initial begin
        forever begin
            @(negedge clk);
            mc++;
            if (hold_prev && !abort_prev) begin
                chk("req_held", bus.mem_req, 1);
                chk("addr_stable", bus.mem_addr, addr_prev);
            end
            hold_prev = bus.mem_req && !bus.mem_gnt;
            abort_prev = rst || !en || frame_start;
            addr_prev = bus.mem_addr;
            if (track && fill_cyc < 0 && fill_level >= PRE) fill_cyc = mc;
            if (pix_data != 16'h0000) begin
                real_cnt++;
                if (track && pix_cyc < 0) pix_cyc = mc;
                if (exp_q.size() == 0) chk("pix_extra", pix_data, 0);
                else chk("pix_order", pix_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // Stimulus sequence
    initial begin
        int n;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("reset");
        step();
        rst = 1'b0;

        step();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        @(negedge clk);
        chk("idle_ignores_fs", busy, 0);

        step();
        en = 1'b1;
        repeat (3) step();

        gnt_pct = 100; lat_lo = 2; lat_hi = 2; de_mode = 2;
        track = 1'b1;
        start_frame();
        @(negedge clk);
        chk("a_req_after_fs", bus.mem_req, 1);
        chk("a_busy", busy, 1);
        wait_idle(2000, "a_done");
        chk("a_all_pixels", exp_q.size(), 0);
        chk("a_xfers", xfer_cnt, N);
        chk("a_last_addr", last_addr, N - 1);
        chk("a_stream_entry", pix_cyc, fill_cyc + 1);
        chk("a_underrun", underrun, 0);
        chk("a_frame_err", frame_err, 0);
        track = 1'b0;

        for (int f = 0; f < 2; f++) clean_frame("b");

        gnt_pct = 100; lat_lo = 20; lat_hi = 20; de_mode = 2;
        start_frame();
        wait_idle(3000, "c_done");
        chk("c_underrun", underrun, 1);
        repeat (10) @(negedge clk);
        chk("c_underrun_sticky", underrun, 1);
        chk("c_frame_err", frame_err, 0);

        de_mode = 0;
        step();
        en = 1'b0;
        step();
        en = 1'b1;
        @(negedge clk);
        chk("en0_underrun", underrun, 0);
        chk("en0_busy", busy, 0);
        chk("en0_fill", fill_level, 0);
        repeat (3) step();

        gnt_pct = 100; lat_lo = 6; lat_hi = 6;
        de_mode = 1; de_pct = 30;
        start_frame();
        wait_pops(40, 1000);
        start_frame();
        @(negedge clk);
        chk("d_frame_err", frame_err, 1);
        chk("d_fill_flushed", fill_level, 0);
        chk("d_busy", busy, 1);
        wait_idle(3000, "d_done");
        chk("d_all_pixels", exp_q.size(), 0);
        chk("d_frame_err_sticky", frame_err, 1);
        chk("d_underrun", underrun, 0);

        de_mode = 0; lat_lo = 5; lat_hi = 5;
        start_frame();
        n = 0;
        while (fill_level < 12 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("e_fill12", fill_level >= 12, 1);
        chk("e_frame_err_pre", frame_err, 1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk_reset_outputs("e_rst");
        repeat (15) @(negedge clk);
        chk("e_stale_ignored", fill_level, 0);
        chk("e_no_req", bus.mem_req, 0);

        clean_frame("f");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
